// File: rtl/zacore_stage_buffer.sv
// zacore_stage_buffer: elastic valid/ready buffer between two Zacore pipeline
// stages. Circular store of DEPTH opaque payload entries with explicit
// pointer wrap, synchronous flush for redirects, and an occupancy count.
// Optional macro ZACORE_STAGE_BUFFER_BYPASS_EN adds a same-cycle path from
// input to output while the buffer is empty. The default build (macro
// undefined) gives a 1-cycle minimum latency with no combinational path
// from input to output.
module zacore_stage_buffer #(
  parameter int PAYLOAD_W = 65,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  // Any depth outside 1..16 is refused when the design is elaborated.
  generate
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $fatal(1, "zacore_stage_buffer: DEPTH must be in 1..16");
    end
  endgenerate

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;
  logic                 empty, full, push, pop, pass;

  // Pointers step through 0..DEPTH-1 and wrap explicitly, so depths that
  // are not a power of two never reach an unused slot.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign in_ready  = ~full;      // registered state only, never out_ready
  assign occupancy = count;

`ifdef ZACORE_STAGE_BUFFER_BYPASS_EN
  // When empty, the offered payload is shown at once; if it is taken the
  // same cycle it never touches the store.
  assign out_valid   = ~empty | (in_valid & ~flush);
  assign out_payload = empty ? in_payload : mem[head];
  assign pass        = empty & in_valid & out_ready & ~flush;
`else
  assign out_valid   = ~empty;
  assign out_payload = mem[head];
  assign pass        = 1'b0;
`endif

  // pop only counts stored entries; a pass-through consumes nothing.
  assign push = in_valid & in_ready & ~flush & ~pass;
  assign pop  = ~empty & out_ready & ~flush;

  // Pointer and count state; flush and reset both return to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= bump(tail);
      if (pop)  head <= bump(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload store is not reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_payload;
  end

endmodule

// File: tb/tb_zacore_stage_buffer.sv
// Bench for zacore_stage_buffer: three instances (DEPTH 1, 2, 3) share one
// directed stimulus stream. A queue model per instance predicts every
// output each cycle; directed literals pin the model to hand-worked values.
module tb_zacore_stage_buffer;
  localparam int PW = 65;
  typedef logic [PW-1:0] pl_t;
`ifdef ZACORE_STAGE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  pl_t  in_payload = '0;
  logic [2:0] ir, ov;
  pl_t  op [3];
  logic       occ1;
  logic [1:0] occ2, occ3;

  int unsigned vectors = 0, miscompares = 0;
  int   dep [3] = '{1, 2, 3};
  pl_t  mq [3][$];
  bit   seen5 = 1'b0;

  always #5 clk = ~clk;

  zacore_stage_buffer #(.PAYLOAD_W(PW), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_payload(in_payload), .out_valid(ov[0]), .out_ready(out_ready),
    .out_payload(op[0]), .occupancy(occ1));
  zacore_stage_buffer #(.PAYLOAD_W(PW), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_payload(in_payload), .out_valid(ov[1]), .out_ready(out_ready),
    .out_payload(op[1]), .occupancy(occ2));
  zacore_stage_buffer #(.PAYLOAD_W(PW), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_payload(in_payload), .out_valid(ov[2]), .out_ready(out_ready),
    .out_payload(op[2]), .occupancy(occ3));

  task automatic chk(input string name, input pl_t act, input pl_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int occ_of(input int i);
    case (i)
      0:       return int'(occ1);
      1:       return int'(occ2);
      default: return int'(occ3);
    endcase
  endfunction

  // Model: a FIFO queue per instance, advanced by the handshake rules.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      bit bp, can_push;
      if (rst || flush) mq[i].delete();
      else begin
        bp = 1'b0;
`ifdef ZACORE_STAGE_BUFFER_BYPASS_EN
        bp = (mq[i].size() == 0) && in_valid && out_ready;
`endif
        if (!bp) begin
          can_push = in_valid && (mq[i].size() < dep[i]);
          if (mq[i].size() > 0 && out_ready) void'(mq[i].pop_front());
          if (can_push) mq[i].push_back(in_payload);
        end
      end
    end
  end

  // Compare every instance against the model mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      bit ev;
      n  = mq[i].size();
      ev = (n > 0);
`ifdef ZACORE_STAGE_BUFFER_BYPASS_EN
      ev = ev || (in_valid && !flush && !rst);
`endif
      chk($sformatf("d%0d out_valid", dep[i]), pl_t'(ov[i]), pl_t'(ev));
      chk($sformatf("d%0d in_ready", dep[i]), pl_t'(ir[i]), pl_t'(n < dep[i]));
      chk($sformatf("d%0d occupancy", dep[i]), pl_t'(occ_of(i)), pl_t'(n));
      if (ev)
        chk($sformatf("d%0d out_payload", dep[i]), op[i], (n > 0) ? mq[i][0] : in_payload);
    end
    if (ov[1] && op[1] == pl_t'(5)) seen5 = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input pl_t p, input logic r);
    in_valid = v; in_payload = p; out_ready = r;
  endtask

  initial begin
    // Reset state
    rst = 1'b1; drive(0, '0, 0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("reset out_valid", pl_t'(ov[1]), pl_t'(0));
    chk("reset in_ready", pl_t'(ir[1]), pl_t'(1));
    chk("reset occupancy", pl_t'(occ2), pl_t'(0));

    // Reset asserted mid-stream with one entry held
    drive(1, 'h11, 0); tick();
    chk("pre-rst occupancy", pl_t'(occ2), pl_t'(1));
    rst = 1'b1; #1;
    chk("async rst occupancy", pl_t'(occ2), pl_t'(0));
    chk("async rst in_ready", pl_t'(ir[1]), pl_t'(1));
    tick();
    rst = 1'b0; #1;
    chk("post-rst out_valid", pl_t'(ov[1]), pl_t'(BYP));
    chk("post-rst occupancy", pl_t'(occ2), pl_t'(0));
    tick();
    chk("held accept occupancy", pl_t'(occ2), pl_t'(1));
    chk("held accept payload", op[1], pl_t'('h11));
    drive(0, '0, 1); tick(); tick(); tick();

    // Fill and drain, DEPTH 2
    drive(1, 'hA, 0); tick();
    drive(1, 'hB, 0); tick();
    drive(0, '0, 0);
    chk("fill occupancy", pl_t'(occ2), pl_t'(2));
    chk("fill in_ready", pl_t'(ir[1]), pl_t'(0));
    chk("fill head", op[1], pl_t'('hA));
    tick();
    chk("stall head", op[1], pl_t'('hA));
    drive(0, '0, 1); tick();
    chk("drain second", op[1], pl_t'('hB));
    chk("drain occupancy", pl_t'(occ2), pl_t'(1));
    tick();
    chk("drained occupancy", pl_t'(occ2), pl_t'(0));
    tick();

    // Flush with a simultaneous offer
    drive(1, 'h21, 0); tick();
    drive(1, 'h22, 0); tick();
    flush = 1'b1; drive(1, 'h5, 0); tick();
    chk("flush occupancy", pl_t'(occ2), pl_t'(0));
    chk("flush out_valid", pl_t'(ov[1]), pl_t'(0));
    chk("flush in_ready", pl_t'(ir[1]), pl_t'(1));
    flush = 1'b0; drive(0, '0, 1); tick(); tick();
    chk("flushed payload never shown", pl_t'(seen5), pl_t'(0));

    // Full with a pop in the same cycle
    drive(1, 'h31, 0); tick();
    drive(1, 'h32, 0); tick();
    drive(1, 'h33, 1);
    chk("full in_ready", pl_t'(ir[1]), pl_t'(0));
    tick();
    chk("full pop occupancy", pl_t'(occ2), pl_t'(1));
    chk("full pop in_ready", pl_t'(ir[1]), pl_t'(1));
    chk("full pop head", op[1], pl_t'('h32));
    tick();
    chk("late push head", op[1], pl_t'('h33));
    drive(0, '0, 1); tick(); tick(); tick();

    // Streaming through DEPTH 3, wrapping the pointers several times
    for (int k = 1; k <= 10; k++) begin
      drive(1, pl_t'(k), 1); tick();
      chk($sformatf("stream %0d", k), op[2], pl_t'(k));
    end
    drive(0, '0, 1); tick();
    chk("stream end out_valid", pl_t'(ov[2]), pl_t'(0));
    tick();

    // DEPTH 1 under continuous flow
    drive(1, 'h40, 1); tick();
    chk("d1 flow out_valid 1", pl_t'(ov[0]), pl_t'(1));
    chk("d1 flow in_ready 1", pl_t'(ir[0]), pl_t'(BYP));
    tick();
    chk("d1 flow out_valid 2", pl_t'(ov[0]), pl_t'(BYP));
    chk("d1 flow in_ready 2", pl_t'(ir[0]), pl_t'(1));
    drive(0, '0, 1); tick(); tick();

`ifdef ZACORE_STAGE_BUFFER_BYPASS_EN
    // Same-cycle pass-through while empty
    drive(1, 'h7, 1); #1;
    chk("bypass out_valid", pl_t'(ov[1]), pl_t'(1));
    chk("bypass payload", op[1], pl_t'('h7));
    chk("bypass occupancy", pl_t'(occ2), pl_t'(0));
    tick();
    chk("bypass after occupancy", pl_t'(occ2), pl_t'(0));
    drive(0, '0, 1); tick();
`endif

    drive(0, '0, 0); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
